// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array readout blocks.
// Holds the drain FSM encoding, the PE accumulator width and a width helper.
package systolic_pkg;

    localparam int ACC_W_DEFAULT = 20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/acc_requant.sv
// Combinational requantiser: logical right shift, then unsigned saturation
// to OUT_W bits. Shared by the accumulator readout paths.
module acc_requant #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] data_o
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

    logic [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_i >> SHIFT;
        data_o  = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/acc_drain.sv
// Snapshots a PE column's accumulators on iDone, clears the PEs in the same
// cycle and streams the requantised words out over oValid/iReady.
module acc_drain
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0,
    parameter int IDX_W = clog2(N)
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic [N*ACC_W-1:0] iAcc,
    input  logic               iDone,
    output logic               oClearAcc,
    output logic               oValid,
    input  logic               iReady,
    output logic [OUT_W-1:0]   oData,
    output logic [IDX_W-1:0]   oIndex,
    output logic               oLast,
    output logic               oBusy,
    output logic               oOverflow
);

    // Handshake: a word transfers on any rising edge where oValid && iReady.
    // oValid stays high, with oData/oIndex/oLast stable, until that transfer.

    drain_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N*ACC_W-1:0] bank_q, bank_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;

    logic               hs;
    logic               capture;
    logic [IDX_W-1:0]   idx_nxt;
    logic [ACC_W-1:0]   sel_word;
    logic [ACC_W-1:0]   rq_in;
    logic [OUT_W-1:0]   rq_out;

    // oData is registered, so the requantiser looks one word ahead: either
    // PE0 of the incoming snapshot or the bank entry after the current index.
    acc_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc_i  (rq_in),
        .data_o (rq_out)
    );

    always_comb begin
        hs       = valid_q && iReady;
        capture  = iDone && ((state_q == ST_IDLE) || (hs && last_q));
        idx_nxt  = idx_q + IDX_W'(1);
        sel_word = '0;
        for (int k = 0; k < N; k++) begin
            if (IDX_W'(k) == idx_nxt) begin
                sel_word = bank_q[k*ACC_W +: ACC_W];
            end
        end
        rq_in = capture ? iAcc[ACC_W-1:0] : sel_word;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q;

        if (iDone && !capture) begin
            ovf_d = 1'b1;
        end

        if (capture) begin
            state_d = ST_DRAIN;
            bank_d  = iAcc;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = rq_out;
            last_d  = 1'b0;
        end else if (hs && last_q) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
        end else if (hs) begin
            idx_d  = idx_nxt;
            data_d = rq_out;
            last_d = (idx_nxt == IDX_W'(N - 1));
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bank_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oClearAcc = capture && iRstN;
    assign oValid    = valid_q;
    assign oData     = data_q;
    assign oIndex    = idx_q;
    assign oLast     = last_q;
    assign oBusy     = (state_q == ST_DRAIN);
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: two instances (SHIFT=0 and SHIFT=4) share stimulus and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_acc_drain;

    localparam int N     = 4;
    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int IDX_W = 2;

    logic               iClk = 1'b0;
    logic               iRstN = 1'b0;
    logic [N*ACC_W-1:0] iAcc = '0;
    logic               iDone = 1'b0;
    logic               iReady = 1'b1;

    logic               clr_a, val_a, last_a, busy_a, ovf_a;
    logic [OUT_W-1:0]   data_a;
    logic [IDX_W-1:0]   idx_a;
    logic               clr_b, val_b, last_b, busy_b, ovf_b;
    logic [OUT_W-1:0]   data_b;
    logic [IDX_W-1:0]   idx_b;

    int n_chk  = 0;
    int n_fail = 0;

    acc_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) dut_a (
        .iClk(iClk), .iRstN(iRstN), .iAcc(iAcc), .iDone(iDone),
        .oClearAcc(clr_a), .oValid(val_a), .iReady(iReady), .oData(data_a),
        .oIndex(idx_a), .oLast(last_a), .oBusy(busy_a), .oOverflow(ovf_a)
    );

    acc_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(4)) dut_b (
        .iClk(iClk), .iRstN(iRstN), .iAcc(iAcc), .iDone(iDone),
        .oClearAcc(clr_b), .oValid(val_b), .iReady(iReady), .oData(data_b),
        .oIndex(idx_b), .oLast(last_b), .oBusy(busy_b), .oOverflow(ovf_b)
    );

    // ---------------- clock ----------------
    always #5 iClk = ~iClk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*ACC_W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
    endfunction

    function automatic logic [OUT_W-1:0] rq(input logic [ACC_W-1:0] a, input int s);
        logic [ACC_W-1:0] t;
        t = a >> s;
        return (t > ACC_W'(255)) ? 8'hFF : t[OUT_W-1:0];
    endfunction

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // The queue holds the snapshot words not yet accepted; its head is on the bus.
    logic [ACC_W-1:0] exp_q[$];
    logic             m_ovf = 1'b0;

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (exp_q.size() > 0 && iReady) void'(exp_q.pop_front());
            if (iDone) begin
                if (exp_q.size() == 0) begin
                    for (int k = 0; k < N; k++) exp_q.push_back(iAcc[k*ACC_W +: ACC_W]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic cmp_dut(input string tag, input int s, input logic clr, input logic val,
                           input logic [OUT_W-1:0] dat, input logic [IDX_W-1:0] idx,
                           input logic lst, input logic bsy, input logic ovf);
        int  sz;
        logic e_clr;
        sz    = exp_q.size();
        e_clr = iRstN && iDone && (sz == 0 || (iReady && sz == 1));
        chk({tag, "_clear"},   32'(clr), 32'(e_clr));
        chk({tag, "_valid"},   32'(val), 32'(sz > 0));
        chk({tag, "_data"},    32'(dat), (sz > 0) ? 32'(rq(exp_q[0], s)) : 32'd0);
        chk({tag, "_index"},   32'(idx), (sz > 0) ? 32'(N - sz) : 32'd0);
        chk({tag, "_last"},    32'(lst), 32'(sz == 1));
        chk({tag, "_busy"},    32'(bsy), 32'(sz > 0));
        chk({tag, "_overflow"}, 32'(ovf), 32'(m_ovf));
    endtask

    always @(negedge iClk) begin
        cmp_dut("mdl_a", 0, clr_a, val_a, data_a, idx_a, last_a, busy_a, ovf_a);
        cmp_dut("mdl_b", 4, clr_b, val_b, data_b, idx_b, last_b, busy_b, ovf_b);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        iRstN = 1'b0; iDone = 1'b0; iReady = 1'b1;
        cyc(); cyc();
        iRstN = 1'b1;
        @(negedge iClk);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_data",  32'(data_a), 32'd0);
        chk("rst_ovf",   32'(ovf_a), 32'd0);
        cyc();

        // basic drain
        iAcc = pack(10, 20, 30, 40); iDone = 1'b1;
        @(negedge iClk);
        chk("basic_clear", 32'(clr_a), 32'd1);
        cyc(); iDone = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge iClk);
            chk("basic_data",  32'(data_a), 32'((k + 1) * 10));
            chk("basic_index", 32'(idx_a), 32'(k));
            chk("basic_last",  32'(last_a), 32'(k == N - 1));
            cyc();
        end
        @(negedge iClk);
        chk("basic_busy_end", 32'(busy_a), 32'd0);
        cyc();

        // saturation / shift on the SHIFT=4 instance
        iAcc = pack(32'h00FF0, 32'h01000, 32'h00120, 0); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        @(negedge iClk); chk("sat_pe0", 32'(data_b), 32'hFF); cyc();
        @(negedge iClk); chk("sat_pe1", 32'(data_b), 32'hFF); cyc();
        @(negedge iClk); chk("sat_pe2", 32'(data_b), 32'h12); chk("sat_pe2_noshift", 32'(data_a), 32'hFF); cyc();
        @(negedge iClk); chk("sat_pe3", 32'(data_b), 32'h00); cyc();

        // backpressure at index 1
        iAcc = pack(1, 2, 3, 4); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        cyc();
        iReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge iClk);
            chk("bp_valid", 32'(val_a), 32'd1);
            chk("bp_data",  32'(data_a), 32'd2);
            chk("bp_index", 32'(idx_a), 32'd1);
            cyc();
        end
        iReady = 1'b1;
        cyc();
        @(negedge iClk);
        chk("bp_resume_index", 32'(idx_a), 32'd2);
        chk("bp_resume_data",  32'(data_a), 32'd3);
        cyc(); cyc();

        // back-to-back capture on the final handshake
        iAcc = pack(11, 12, 13, 14); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        cyc(); cyc(); cyc();
        iAcc = pack(21, 22, 23, 24); iDone = 1'b1;
        @(negedge iClk);
        chk("b2b_last",  32'(last_a), 32'd1);
        chk("b2b_clear", 32'(clr_a), 32'd1);
        cyc(); iDone = 1'b0;
        @(negedge iClk);
        chk("b2b_valid", 32'(val_a), 32'd1);
        chk("b2b_index", 32'(idx_a), 32'd0);
        chk("b2b_data",  32'(data_a), 32'd21);
        chk("b2b_ovf",   32'(ovf_a), 32'd0);
        cyc(); cyc(); cyc(); cyc();

        // overflow: iDone while draining at index 1
        iAcc = pack(5, 6, 7, 8); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        cyc();
        iAcc = pack(100, 101, 102, 103); iDone = 1'b1;
        @(negedge iClk);
        chk("ovf_clear", 32'(clr_a), 32'd0);
        cyc(); iDone = 1'b0;
        @(negedge iClk);
        chk("ovf_flag", 32'(ovf_a), 32'd1);
        chk("ovf_data_kept", 32'(data_a), 32'd7);
        cyc(); cyc();
        @(negedge iClk);
        chk("ovf_sticky", 32'(ovf_a), 32'd1);
        chk("ovf_idle",   32'(busy_a), 32'd0);
        cyc();

        // reset mid-drain at index 2
        iAcc = pack(31, 32, 33, 34); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        cyc(); cyc();
        #2 iRstN = 1'b0;
        #1;
        chk("rstmid_valid", 32'(val_a), 32'd0);
        chk("rstmid_data",  32'(data_a), 32'd0);
        chk("rstmid_index", 32'(idx_a), 32'd0);
        chk("rstmid_busy",  32'(busy_a), 32'd0);
        chk("rstmid_ovf",   32'(ovf_a), 32'd0);
        chk("rstmid_clear", 32'(clr_a), 32'd0);
        cyc();
        iRstN = 1'b1;
        cyc();
        iAcc = pack(41, 42, 43, 44); iDone = 1'b1;
        cyc(); iDone = 1'b0;
        @(negedge iClk);
        chk("post_rst_index", 32'(idx_a), 32'd0);
        chk("post_rst_data",  32'(data_a), 32'd41);
        cyc(); cyc(); cyc(); cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
